// File: rtl/pisa_pkg.sv
// Shared types and geometry for the PISA display path.
package pisa_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } pw_state_t;

    localparam int unsigned PIX_W        = 8;
    localparam int unsigned WORD_W       = 32;
    localparam int unsigned PIX_PER_WORD = 4;
    localparam int unsigned LANE_W       = $clog2(PIX_PER_WORD);

    localparam int unsigned FRAME_WIDTH         = 256;
    localparam int unsigned FRAME_HEIGHT        = 256;
    localparam int unsigned FRAME_WORDS_DEFAULT = FRAME_WIDTH * FRAME_HEIGHT / PIX_PER_WORD;

endpackage

// File: rtl/pixel_packer.sv
// Packs consecutive 8-bit pixels into a 32-bit word, lane 0 in the low byte.
module pixel_packer
    import pisa_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic              i_last,
    input  logic [PIX_W-1:0]  i_pix,
    output logic              o_commit_c,
    output logic [WORD_W-1:0] o_word_c
);

    logic [LANE_W-1:0] r_lane;
    logic [WORD_W-1:0] r_acc;
    logic [WORD_W-1:0] w_word;
    logic              w_commit;

    // Current pixel merged into its lane; unfilled lanes stay zero.
    always_comb begin
        w_word = r_acc;
        for (int unsigned i = 0; i < PIX_PER_WORD; i++) begin
            if (r_lane == LANE_W'(i)) begin
                w_word[i*PIX_W +: PIX_W] = i_pix;
            end
        end
    end

    assign w_commit   = i_load && (i_last || (r_lane == LANE_W'(PIX_PER_WORD - 1)));
    assign o_commit_c = w_commit;
    assign o_word_c   = w_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lane <= '0;
            r_acc  <= '0;
        end else if (i_clear || w_commit) begin
            r_lane <= '0;
            r_acc  <= '0;
        end else if (i_load) begin
            r_lane <= r_lane + LANE_W'(1);
            r_acc  <= w_word;
        end
    end

endmodule

// File: rtl/pixel_writer.sv
// Frame-buffer write engine: accepts a pixel stream and writes packed words to the pixel RAM.
module pixel_writer
    import pisa_pkg::*;
#(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              pix_last,
    output logic              pix_ready,
    output logic              wren,
    output logic [ADDR_W-1:0] wraddress,
    output logic [WORD_W-1:0] data,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [63:0]       ADDR_SPAN = 64'(1) << ADDR_W;
    localparam logic [ADDR_W-1:0] BASE_PTR  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(BASE_ADDR + FRAME_WORDS - 1);

    if ((FRAME_WORDS == 0) || (64'(BASE_ADDR) + 64'(FRAME_WORDS) > ADDR_SPAN)) begin : g_bad_geometry
        $error("pixel_writer: frame does not fit in the word address space");
    end

    pw_state_t         r_state;
    pw_state_t         w_next_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_wren;
    logic [ADDR_W-1:0] r_wraddress;
    logic [WORD_W-1:0] r_data;
    logic              r_busy;
    logic              r_frame_done;

    logic              w_handshake;
    logic              w_commit;
    logic              w_frame_end;
    logic [WORD_W-1:0] w_word;

    // Ready is a function of state and start only, never of pix_valid.
    assign pix_ready   = (r_state == ACTIVE) && !start;
    assign w_handshake = pix_valid && pix_ready;
    assign w_frame_end = w_commit && (pix_last || (r_ptr == LAST_PTR));

    pixel_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_handshake),
        .i_clear    (start),
        .i_last     (pix_last),
        .i_pix      (pix_data),
        .o_commit_c (w_commit),
        .o_word_c   (w_word)
    );

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = ACTIVE;
                end
            end
            ACTIVE: begin
                if (start) begin
                    w_next_state = ACTIVE;
                end else if (w_frame_end) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = start ? ACTIVE : IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Pointer and write-port registers; start and commit never coincide since ready drops on start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr        <= BASE_PTR;
            r_wren       <= 1'b0;
            r_wraddress  <= BASE_PTR;
            r_data       <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_wren       <= w_commit;
            r_frame_done <= w_frame_end;
            r_busy       <= (w_next_state != IDLE);
            if (start) begin
                r_ptr <= BASE_PTR;
            end else if (w_commit) begin
                r_wraddress <= r_ptr;
                r_data      <= w_word;
                r_ptr       <= r_ptr + ADDR_W'(1);
            end
        end
    end

    assign wren       = r_wren;
    assign wraddress  = r_wraddress;
    assign data       = r_data;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
